pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the general-purpose PLL wrapper.
- Runs on the free-running board/reference clock.
- Drives the PLL's rst input and consumes its asynchronous locked output.
- Produces a clean system reset and a ready flag for the core. It retries the PLL on lock timeout and re-sequences on lock loss.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per attempt (>=1).
- LOCK_TIMEOUT, 50000: cycles to wait for lock before re-resetting the PLL (>=1).
- SETTLE_CYCLES, 1024: consecutive synchronized-lock cycles required before releasing sys_rst (>=1).
- CNT_W, 20: width of the shared cycle counter. It must hold max(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES).
- RETRY_W, 4: width of the retry counter.

Ports:
- clk: input, 1. Free-running reference clock.
- rst: input, 1. Asynchronous, active-high reset.
- soft_rst_req: input, 1. Synchronous request to re-run the full sequence.
- pll_locked: input, 1. PLL locked, asynchronous to clk.
- pll_rst: output, 1. Reset to the PLL.
- sys_rst: output, 1. Active-high system reset. Downstream domains synchronize it.
- ready: output, 1. High only in RUN.
- retry_count: output, RETRY_W. Number of lock timeouts since rst. Saturates.
- state_dbg: output, 2. Encoded current state.

Behaviour:
- pll_locked passes through a 2-flop synchronizer (lock_s). All decisions use lock_s, so there are 2 cycles of latency from pin to decision.
- Reset values: state=PLL_RESET, cnt=0, pll_rst=1, sys_rst=1, ready=0, retry_count=0, state_dbg=0, synchronizer flops=0.
- State encoding: PLL_RESET=0, WAIT_LOCK=1, SETTLE=2, RUN=3. All outputs are registered.
- PLL_RESET:
  - pll_rst=1, sys_rst=1. cnt increments.
  - When cnt==RST_CYCLES-1: go to WAIT_LOCK, cnt=0.
- WAIT_LOCK:
  - pll_rst=0, sys_rst=1.
  - If lock_s=1: go to SETTLE, cnt=0.
  - Else if cnt==LOCK_TIMEOUT-1: go to PLL_RESET, cnt=0, retry_count+1 (saturates at all-ones).
  - Else cnt increments.
- SETTLE:
  - pll_rst=0, sys_rst=1.
  - If lock_s=0: go to WAIT_LOCK, cnt=0. No retry increment.
  - Else if cnt==SETTLE_CYCLES-1: go to RUN.
  - Else cnt increments.
- RUN:
  - pll_rst=0, sys_rst=0, ready=1.
  - Lock loss (see Optional Feature) goes to PLL_RESET, cnt=0, and asserts sys_rst on the next cycle.
- soft_rst_req=1 in any state: go to PLL_RESET, cnt=0.
  - Highest priority. It wins over a simultaneous timeout or settle completion.
  - retry_count is unchanged.
- Held soft_rst_req keeps the block in PLL_RESET with cnt=0.
- Asynchronous rst mid-sequence returns immediately to the reset values. There is no partial state.
- ready and sys_rst are always complementary. In RUN, sys_rst deasserts on the same edge ready asserts.

Optional Feature:
- Macro: PLL_LOCK_LOSS_FILTER_EN.
- Defined:
  - Adds parameter LOSS_FILTER (default 8) and a filter counter.
  - In RUN, lock_s must be 0 for LOSS_FILTER consecutive cycles before leaving RUN. Any lock_s=1 clears the filter counter.
  - The filter counter resets to 0 on rst and on RUN entry.
- Undefined:
  - A single lock_s=0 cycle in RUN causes the transition to PLL_RESET.

Decomposition:
- Shared package pll_seq_pkg holds:
  - the state enum (PLL_RESET, WAIT_LOCK, SETTLE, RUN);
  - the default timing constants.
- One natural sub-module: sync_2ff, a generic 2-flop bit synchronizer with async active-high reset. It is used for pll_locked.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=8):
- Release rst, raise pll_locked 10 cycles later and hold it -> pll_rst is high for exactly 4 cycles; sys_rst falls and ready rises 8 cycles after lock_s rises; retry_count=0.
- Keep pll_locked=0 -> pll_rst re-pulses every 24 cycles (4+20); retry_count counts 1,2,3…, saturates at 15 and stays there.
- In SETTLE at cnt=5, drop pll_locked for 1 cycle -> return to WAIT_LOCK, settle restarts (full 8 cycles needed), retry_count unchanged.
- In RUN, drop pll_locked for 3 cycles:
  - without macro -> PLL_RESET, sys_rst=1, pll_rst=1;
  - with macro (LOSS_FILTER=8) -> stays in RUN; an 8-cycle drop -> PLL_RESET.
- Assert soft_rst_req in the same cycle as the WAIT_LOCK timeout -> PLL_RESET, retry_count not incremented.
- Assert rst asynchronously mid-SETTLE -> all outputs return to reset values immediately without a clock edge.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared state encoding and default timing constants for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    SETTLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 50000;
  localparam int DEF_SETTLE_CYCLES = 1024;
  localparam int DEF_CNT_W         = 20;
  localparam int DEF_RETRY_W       = 4;
  localparam int DEF_LOSS_FILTER   = 8;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop bit synchronizer with asynchronous active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, lock wait with retry, settle time and system reset release.
// Optional macro PLL_LOCK_LOSS_FILTER_EN debounces lock loss while in RUN.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int RETRY_W       = DEF_RETRY_W
`ifdef PLL_LOCK_LOSS_FILTER_EN
  ,
  parameter int LOSS_FILTER   = DEF_LOSS_FILTER
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               soft_rst_req,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic [RETRY_W-1:0] retry_count,
  output logic [1:0]         state_dbg
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_rst_q, sys_rst_d;
  logic               ready_q, ready_d;

`ifdef PLL_LOCK_LOSS_FILTER_EN
  localparam int FILT_W = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOSS_FILTER - 1);
  logic [FILT_W-1:0] filt_q, filt_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
`ifdef PLL_LOCK_LOSS_FILTER_EN
    filt_d  = '0;
`endif

    if (soft_rst_req) begin
      state_d = PLL_RESET;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        PLL_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = PLL_RESET;
            cnt_d   = '0;
            if (retry_q != '1) retry_d = retry_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SETTLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == SETTLE_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          cnt_d = '0;
`ifdef PLL_LOCK_LOSS_FILTER_EN
          // Consecutive low cycles are counted; any high sample restarts the count.
          if (!lock_s) begin
            if (filt_q == FILT_LAST) begin
              state_d = PLL_RESET;
            end else begin
              filt_d = filt_q + 1'b1;
            end
          end
`else
          if (!lock_s) state_d = PLL_RESET;
`endif
        end
        default: begin
          state_d = PLL_RESET;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    pll_rst_d = (state_d == PLL_RESET);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PLL_RESET;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
`ifdef PLL_LOCK_LOSS_FILTER_EN
      filt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
`ifdef PLL_LOCK_LOSS_FILTER_EN
      filt_q    <= filt_d;
`endif
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign retry_count = retry_q;
  assign state_dbg   = state_q;

endmodule
